// File: rtl/icache_set_assoc.sv
// Set-associative I-cache, tree pseudo-LRU, multi-word refill; hits answer 1 cycle after lookup.
// Misses stall fetch (read_request ignored) until the line is refilled word by word from memory.
module icache_set_assoc #(
    parameter int CACHE_SIZE = 1024,
    parameter int WAYS       = 2,
    parameter int LINE_WORDS = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        read_request,
    input  logic [31:0] addr,
    input  logic        flush,
    output logic        read_response,
    output logic [31:0] read_data,
    output logic        memory_read_request,
    output logic [31:0] memory_addr,
    input  logic [31:0] memory_read_data,
    input  logic        memory_read_response
);
    localparam int NUM_SETS = CACHE_SIZE / (4 * LINE_WORDS * WAYS);
    localparam int OFF_B    = $clog2(LINE_WORDS);
    localparam int IDX_B    = $clog2(NUM_SETS);
    localparam int WAY_B    = $clog2(WAYS);
    localparam int OFF_W    = (OFF_B > 0) ? OFF_B : 1;
    localparam int IDX_W    = (IDX_B > 0) ? IDX_B : 1;
    localparam int WAY_W    = (WAY_B > 0) ? WAY_B : 1;
    localparam int TAG_W    = 30 - OFF_B - IDX_B;
    localparam int PL_W     = (WAYS > 1) ? WAYS - 1 : 1;

    typedef enum logic [2:0] {S_IDLE, S_REFILL_REQ, S_REFILL_WAIT, S_GAP, S_RESPOND} state_t;

    logic [31:0]      r_data  [NUM_SETS][WAYS][LINE_WORDS];
    logic [TAG_W-1:0] r_tag   [NUM_SETS][WAYS];
    logic [WAYS-1:0]  r_valid [NUM_SETS];
    logic [PL_W-1:0]  r_plru  [NUM_SETS];

    state_t           r_state;
    logic [IDX_W-1:0] r_idx;
    logic [TAG_W-1:0] r_tagl;
    logic [OFF_W-1:0] r_off;
    logic [OFF_W-1:0] r_k;
    logic [WAY_W-1:0] r_way;
    logic [31:0]      r_word;
    logic             r_flush_pend;

    logic [IDX_W-1:0] w_idx;
    logic [TAG_W-1:0] w_tag;
    logic [OFF_W-1:0] w_off;
    logic [31:0]      w_base;
    logic             w_hit;
    logic [WAY_W-1:0] w_hit_way;
    logic [31:0]      w_hit_word;
    logic [WAY_W-1:0] w_victim;
    logic             w_cap;
    logic             w_last;
    logic             w_clear;

    // Heap-ordered tree: node n lives at bit n-1, children 2n/2n+1; a 1 points the victim right.
    function automatic logic [WAY_W-1:0] plru_victim(input logic [PL_W-1:0] b);
        int   n;
        logic bt;
        n = 1;
        for (int l = 0; l < WAY_B; l++) begin
            bt = 1'b0;
            for (int j = 1; j < WAYS; j++) if (j == n) bt = b[j-1];
            n = 2 * n + (bt ? 1 : 0);
        end
        return WAY_W'(n - WAYS);
    endfunction

    function automatic logic [PL_W-1:0] plru_touch(input logic [PL_W-1:0] b, input logic [WAY_W-1:0] w);
        int              n;
        logic            dir;
        logic [PL_W-1:0] r;
        r = b;
        n = 1;
        for (int l = 0; l < WAY_B; l++) begin
            dir = w[WAY_B-1-l];
            for (int j = 1; j < WAYS; j++) if (j == n) r[j-1] = ~dir;
            n = 2 * n + (dir ? 1 : 0);
        end
        return r;
    endfunction

    assign w_off   = OFF_W'((addr >> 2) & 32'(LINE_WORDS - 1));
    assign w_idx   = IDX_W'((addr >> (2 + OFF_B)) & 32'(NUM_SETS - 1));
    assign w_tag   = TAG_W'(addr >> (2 + OFF_B + IDX_B));
    assign w_base  = addr & ~32'(4 * LINE_WORDS - 1);
    assign w_cap   = (r_state == S_REFILL_REQ || r_state == S_REFILL_WAIT) && memory_read_response;
    assign w_last  = (r_k == OFF_W'(LINE_WORDS - 1));
    assign w_clear = (r_state == S_IDLE && flush) || (r_state == S_RESPOND && (r_flush_pend || flush));

    always_comb begin
        w_hit      = 1'b0;
        w_hit_way  = '0;
        w_hit_word = '0;
        w_victim   = plru_victim(r_plru[w_idx]);
        for (int w = 0; w < WAYS; w++) begin
            if (!w_hit && r_valid[w_idx][w] && r_tag[w_idx][w] == w_tag) begin
                w_hit      = 1'b1;
                w_hit_way  = WAY_W'(w);
                w_hit_word = r_data[w_idx][w][w_off];
            end
        end
        // Lowest invalid way wins over the tree choice; a same-cycle flush empties the set.
        for (int w = WAYS - 1; w >= 0; w--) if (!r_valid[w_idx][w]) w_victim = WAY_W'(w);
        if (flush) w_victim = '0;
    end

    always_ff @(posedge clk) begin
        if (w_cap) r_data[r_idx][r_way][r_k] <= memory_read_data;
        if (w_cap && w_last) r_tag[r_idx][r_way] <= r_tagl;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int s = 0; s < NUM_SETS; s++) begin
                r_valid[s] <= '0;
                r_plru[s]  <= '0;
            end
            r_state             <= S_IDLE;
            r_idx               <= '0;
            r_tagl              <= '0;
            r_off               <= '0;
            r_k                 <= '0;
            r_way               <= '0;
            r_word              <= '0;
            r_flush_pend        <= 1'b0;
            read_response       <= 1'b0;
            read_data           <= '0;
            memory_read_request <= 1'b0;
            memory_addr         <= '0;
        end else begin
            if (w_clear) begin
                for (int s = 0; s < NUM_SETS; s++) begin
                    r_valid[s] <= '0;
                    r_plru[s]  <= '0;
                end
            end
            if (r_state != S_IDLE && flush) r_flush_pend <= 1'b1;
            case (r_state)
                S_IDLE: begin
                    read_response <= 1'b0;
                    r_flush_pend  <= 1'b0;
                    if (read_request) begin
                        if (w_hit && !flush) begin
                            read_response  <= 1'b1;
                            read_data      <= w_hit_word;
                            r_plru[w_idx]  <= plru_touch(r_plru[w_idx], w_hit_way);
                        end else begin
                            r_idx               <= w_idx;
                            r_tagl              <= w_tag;
                            r_off               <= w_off;
                            r_way               <= w_victim;
                            r_k                 <= '0;
                            memory_read_request <= 1'b1;
                            memory_addr         <= w_base;
                            r_state             <= S_REFILL_REQ;
                        end
                    end
                end
                S_REFILL_REQ, S_REFILL_WAIT: begin
                    if (memory_read_response) begin
                        memory_read_request <= 1'b0;
                        r_k                 <= r_k + OFF_W'(1);
                        if (r_k == r_off) r_word <= memory_read_data;
                        if (w_last) begin
                            read_response <= 1'b1;
                            read_data     <= (r_k == r_off) ? memory_read_data : r_word;
                            if (!(r_flush_pend || flush)) begin
                                r_valid[r_idx][r_way] <= 1'b1;
                                r_plru[r_idx]         <= plru_touch(r_plru[r_idx], r_way);
                            end
                            r_state <= S_RESPOND;
                        end else begin
                            memory_addr <= memory_addr + 32'd4;
                            r_state     <= S_GAP;
                        end
                    end else begin
                        r_state <= S_REFILL_WAIT;
                    end
                end
                S_GAP: begin
                    memory_read_request <= 1'b1;
                    r_state             <= S_REFILL_REQ;
                end
                S_RESPOND: begin
                    read_response <= 1'b0;
                    r_flush_pend  <= 1'b0;
                    r_state       <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: doc/icache_set_assoc.md
# icache_set_assoc

Parametrised set-associative instruction cache with multi-word line refill. It is the next generation of the direct-mapped `ICache` and sits in the same place: between the fetch stage and the instruction `Memory`. Both sides use the same request/response handshake. New behaviour over `ICache`:
- configurable associativity and line length;
- per-set pseudo-LRU replacement;
- a single-cycle flush input for `fence.i`.

## Interface
- CACHE_SIZE, 1024: total data capacity in bytes; power of two.
- WAYS, 2: associativity; power of two, 1..8.
- LINE_WORDS, 4: 32-bit words per line; power of two, 1..16.
- Derived: NUM_SETS = CACHE_SIZE/(4·LINE_WORDS·WAYS) ≥ 1.
- Address split: offset = addr[log2(LINE_WORDS)+1:2], index = next log2(NUM_SETS) bits, tag = remainder up to bit 31; addr[1:0] ignored.
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low; clears all valid and LRU state and all outputs.
- read_request  in  1  fetch request (level); sampled every cycle in IDLE.
- addr  in  32  fetch byte address; must be held until read_response.
- flush  in  1  invalidate every line (one-cycle pulse).
- read_response  out  1  one-cycle pulse: read_data valid.
- read_data  out  32  instruction word for the request being answered.
- memory_read_request  out  1  refill word request to memory.
- memory_addr  out  32  word-aligned refill address.
- memory_read_data  in  32  refill word.
- memory_read_response  in  1  refill word valid (one-cycle pulse).

## Operation
- States:
  - IDLE (lookup)
  - REFILL_REQ
  - REFILL_WAIT
  - GAP
  - RESPOND
- IDLE, read_request=1:
  - Compare tag against all WAYS of the indexed set.
  - Hit: register the word and update LRU (hit way becomes MRU); stay in IDLE.
  - Miss: latch addr, choose victim, go to REFILL_REQ.
- Victim choice:
  - Lowest-index invalid way.
  - If every way is valid: the tree pseudo-LRU victim (for WAYS=2 this is true LRU; for WAYS=1 it is always way 0).
- REFILL_REQ/REFILL_WAIT:
  - memory_read_request=1, memory_addr = line base + 4·k, k = 0..LINE_WORDS-1, in ascending order.
  - Request and address are held until memory_read_response=1.
  - The word is written into the victim line slot k on that cycle.
- GAP: memory_read_request=0 for exactly one cycle between words, then k+1 → REFILL_REQ. After the last word, go to RESPOND.
- RESPOND:
  - Set the victim's valid bit and tag; the victim becomes MRU.
  - Drive the latched requested word; return to IDLE.
- flush in IDLE: all valid bits cleared in one cycle; LRU reset to 0. If read_request=1 in the same cycle, that lookup is treated as a miss.
- flush during a refill:
  - Latched as pending; the refill completes and the response is delivered.
  - The line is not marked valid.
  - The pending flush is applied on entry to IDLE.
- reset low at any time: immediately returns to IDLE with:
  - memory_read_request=0, read_response=0;
  - the in-flight refill abandoned with no response.
- Tag/data storage may be flops or inferred RAM, as long as hit timing holds.

## Timing
- Reset values: read_response=0, read_data=0, memory_read_request=0, memory_addr=0, all valid=0, all LRU=0, state IDLE.
- Hit latency:
  - read_response high in the cycle after read_request is sampled.
  - Back-to-back hits with read_request held high give one response per cycle.
- Miss latency:
  - First cycle of the miss: lookup.
  - Then, per word: cycles until memory_read_response, plus 1 GAP cycle (none after the last word).
  - Then RESPOND; read_response is high in the cycle after the last word is captured.
- While not in IDLE, read_request is ignored and read_response=0 except in the RESPOND-output cycle.
- memory_addr changes only on the cycle after a captured response, never while memory_read_request is high and unanswered.

## Test plan
Common setup: CACHE_SIZE=1024, WAYS=2, LINE_WORDS=4 (NUM_SETS=32, index=addr[8:4]). The memory word at byte address A holds value A.

- Cold miss, addr=0x0:
  - memory_addr sequence is 0x0, 0x4, 0x8, 0xC, with memory_read_request low for one cycle between words.
  - read_response with read_data=0x0.
  - Then addr=0x4 and addr=0x8 hit: response one cycle later, data 0x4 and 0x8, memory_read_request stays 0.
- Unaligned addr=0x6 returns 0x4; addr=0xE returns 0xC; both are hits with no memory traffic.
- LRU eviction, all in set 0:
  - Access 0x000, 0x200, 0x000, then 0x400: the 0x400 miss evicts 0x200.
  - 0x000 then hits.
  - 0x200 then misses and evicts 0x400.
- Flush in IDLE:
  - After filling 0x0, pulse flush.
  - Next 0x0 is a miss with a full 4-word refill.
- Flush during the word-2 refill of 0x100:
  - Refill finishes; read_response with data 0x100.
  - An immediate re-access of 0x100 misses.
- reset low during REFILL_WAIT:
  - memory_read_request drops asynchronously; no read_response.
  - After release, 0x0 is a miss.
